// File: rtl/mna_pkg.sv
// Shared definitions for the MNA request packetizer: flit type codes, FSM state encoding and
// tail-payload field offsets.
package mna_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StHead,
    StBody,
    StTail
  } state_e;

  localparam int unsigned PROT_W       = 3;
  localparam int unsigned TAIL_SEQ_LSB = 0;

  // Tail payload layout from LSB: seq, is_write, strb, prot, zero pad.
  function automatic int unsigned tail_wr_pos(int unsigned seq_w);
    return seq_w;
  endfunction

  function automatic int unsigned tail_strb_lsb(int unsigned seq_w);
    return seq_w + 1;
  endfunction

  function automatic int unsigned tail_prot_lsb(int unsigned seq_w, int unsigned strb_w);
    return seq_w + 1 + strb_w;
  endfunction

endpackage

// File: rtl/mna_request_packetizer_if.sv
// AXI4-Lite request channels plus NoC link signals of the MNA request packetizer.
// master: AXI master / router side; slave: the packetizer.
interface mna_request_packetizer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_VC = 8
);
  localparam int unsigned VC_W   = $clog2(NUM_VC);
  localparam int unsigned FLIT_W = 2 + VC_W + DATA_W;

  logic                ar_valid;
  logic                ar_ready;
  logic [ADDR_W-1:0]   ar_addr;
  logic [2:0]          ar_prot;
  logic                aw_valid;
  logic                aw_ready;
  logic [ADDR_W-1:0]   aw_addr;
  logic [2:0]          aw_prot;
  logic                w_valid;
  logic                w_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic [FLIT_W-1:0]   noc_data;
  logic                noc_valid;
  logic [NUM_VC-1:0]   noc_vc;
  logic [NUM_VC-1:0]   is_on_off;
  logic [NUM_VC-1:0]   is_allocatable;

  modport master (
    output ar_valid, ar_addr, ar_prot, aw_valid, aw_addr, aw_prot,
    output w_valid, w_data, w_strb, is_on_off, is_allocatable,
    input  ar_ready, aw_ready, w_ready, noc_data, noc_valid, noc_vc
  );

  modport slave (
    input  ar_valid, ar_addr, ar_prot, aw_valid, aw_addr, aw_prot,
    input  w_valid, w_data, w_strb, is_on_off, is_allocatable,
    output ar_ready, aw_ready, w_ready, noc_data, noc_valid, noc_vc
  );

endinterface

// File: rtl/mna_vc_select.sv
// Lowest-index priority encoder over the available-VC mask.
module mna_vc_select #(
  parameter int unsigned NUM_VC = 8,
  parameter int unsigned VC_W   = $clog2(NUM_VC)
) (
  input  logic [NUM_VC-1:0] avail_mask_i,
  output logic [VC_W-1:0]   vc_sel_o,
  output logic              avail_o
);

  always_comb begin
    vc_sel_o = '0;
    for (int i = int'(NUM_VC) - 1; i >= 0; i--) begin
      if (avail_mask_i[i]) begin
        vc_sel_o = VC_W'(i);
      end
    end
  end

  assign avail_o = |avail_mask_i;

endmodule

// File: rtl/mna_request_packetizer.sv
// Master-side NoC adapter request path: AXI4-Lite AR / AW+W requests to header/[body]/tail flits.
// Define MNA_REQ_RR_ARB_EN for round-robin read/write arbitration (default: fixed read priority).
module mna_request_packetizer
  import mna_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_VC = 8,
  parameter int unsigned SEQ_W  = 8
) (
  input logic                    clock,
  input logic                    reset,
  mna_request_packetizer_if.slave bus
);

  localparam int unsigned VC_W      = $clog2(NUM_VC);
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned FLIT_W    = 2 + VC_W + DATA_W;
  localparam int unsigned WR_POS    = tail_wr_pos(SEQ_W);
  localparam int unsigned STRB_LSB  = tail_strb_lsb(SEQ_W);
  localparam int unsigned PROT_LSB  = tail_prot_lsb(SEQ_W, STRB_W);

  function automatic logic [FLIT_W-1:0] make_flit(logic [1:0]        ftype,
                                                  logic [VC_W-1:0]   vc,
                                                  logic [DATA_W-1:0] payload);
    return {ftype, vc, payload};
  endfunction

  state_e              state_q;
  logic [VC_W-1:0]     vc_q;
  logic [PROT_W-1:0]   prot_q;
  logic [DATA_W-1:0]   data_q;
  logic [STRB_W-1:0]   strb_q;
  logic                is_write_q;
  logic [SEQ_W-1:0]    seq_q;
  logic [FLIT_W-1:0]   noc_data_q;
  logic [NUM_VC-1:0]   noc_vc_q;

  logic [NUM_VC-1:0]   avail_mask;
  logic [VC_W-1:0]     vc_sel;
  logic                avail;
  logic                idle;
  logic                rd_elig;
  logic                wr_elig;
  logic                grant_rd;
  logic                grant_wr;
  logic                xfer;
  logic [DATA_W-1:0]   tail_payload;

  assign avail_mask = bus.is_allocatable & bus.is_on_off;

  mna_vc_select #(
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W)
  ) u_vc_select (
    .avail_mask_i (avail_mask),
    .vc_sel_o     (vc_sel),
    .avail_o      (avail)
  );

  assign idle    = (state_q == StIdle);
  assign rd_elig = idle && avail && bus.ar_valid;
  // AW and W are only ever taken together.
  assign wr_elig = idle && avail && bus.aw_valid && bus.w_valid;

`ifdef MNA_REQ_RR_ARB_EN
  logic rr_last_q;  // 1: the last grant went to a write
  assign grant_rd = rd_elig && (!wr_elig || rr_last_q);
`else
  assign grant_rd = rd_elig;
`endif
  assign grant_wr = wr_elig && !grant_rd;

  // No ready on the link: a valid cycle on an "on" VC is a completed transfer.
  assign xfer = !idle && bus.is_on_off[vc_q];

  always_comb begin
    tail_payload                             = '0;
    tail_payload[TAIL_SEQ_LSB +: SEQ_W]      = seq_q;
    tail_payload[WR_POS]                     = is_write_q;
    tail_payload[STRB_LSB +: STRB_W]         = strb_q;
    tail_payload[PROT_LSB +: PROT_W]         = prot_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      vc_q       <= '0;
      prot_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      is_write_q <= 1'b0;
      seq_q      <= '0;
      noc_data_q <= '0;
      noc_vc_q   <= '0;
`ifdef MNA_REQ_RR_ARB_EN
      rr_last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_rd || grant_wr) begin
            vc_q       <= vc_sel;
            noc_vc_q   <= NUM_VC'(1) << vc_sel;
            is_write_q <= grant_wr;
            state_q    <= StHead;
`ifdef MNA_REQ_RR_ARB_EN
            rr_last_q  <= grant_wr;
`endif
            if (grant_wr) begin
              prot_q     <= bus.aw_prot;
              data_q     <= bus.w_data;
              strb_q     <= bus.w_strb;
              noc_data_q <= make_flit(FLIT_HEAD, vc_sel, DATA_W'(bus.aw_addr));
            end else begin
              prot_q     <= bus.ar_prot;
              strb_q     <= '0;
              noc_data_q <= make_flit(FLIT_HEAD, vc_sel, DATA_W'(bus.ar_addr));
            end
          end
        end
        StHead: begin
          if (xfer) begin
            if (is_write_q) begin
              state_q    <= StBody;
              noc_data_q <= make_flit(FLIT_BODY, vc_q, data_q);
            end else begin
              state_q    <= StTail;
              noc_data_q <= make_flit(FLIT_TAIL, vc_q, tail_payload);
            end
          end
        end
        StBody: begin
          if (xfer) begin
            state_q    <= StTail;
            noc_data_q <= make_flit(FLIT_TAIL, vc_q, tail_payload);
          end
        end
        StTail: begin
          if (xfer) begin
            state_q    <= StIdle;
            seq_q      <= seq_q + 1'b1;
            noc_data_q <= '0;
            noc_vc_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ar_ready  = grant_rd;
  assign bus.aw_ready  = grant_wr;
  assign bus.w_ready   = grant_wr;
  assign bus.noc_valid = xfer;
  assign bus.noc_data  = noc_data_q;
  assign bus.noc_vc    = noc_vc_q;

endmodule
